// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART programming path: word/byte widths,
// default memory depth and the loader state encoding.
package uart_loader_pkg;

  localparam int unsigned ISA_WIDTH       = 32;
  localparam int unsigned ROM_DEPTH       = 14;
  localparam int unsigned UART_BYTE_WIDTH = 8;
  localparam int unsigned BYTE_CNT_W      = 2;

  typedef enum logic [1:0] {
    UPG_ST_IDLE = 2'd0,
    UPG_ST_RECV = 2'd1,
    UPG_ST_DONE = 2'd2
  } upg_state_e;

endpackage

// File: rtl/uart_word_assembler.sv
// Packs received bytes little-endian into a 32-bit word and pulses
// word_done_o the cycle after the fourth lane is written.
module uart_word_assembler
  import uart_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       en_i,
  input  logic                       rx_valid_i,
  input  logic [UART_BYTE_WIDTH-1:0] rx_data_i,
  output logic [BYTE_CNT_W-1:0]      byte_cnt_o,
  output logic [ISA_WIDTH-1:0]       word_o,
  output logic                       word_done_o
);

  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic [ISA_WIDTH-1:0]  word_q, word_d;
  logic                  done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    done_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && rx_valid_i) begin
      word_d[UART_BYTE_WIDTH*cnt_q +: UART_BYTE_WIDTH] = rx_data_i;
      cnt_d  = cnt_q + BYTE_CNT_W'(1);
      done_d = (cnt_q == BYTE_CNT_W'(3));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      done_q <= done_d;
    end
  end

  assign byte_cnt_o  = cnt_q;
  assign word_o      = word_q;
  assign word_done_o = done_q;

endmodule

// File: rtl/uart_loader.sv
// UART programming loader: streams assembled words into instruction/data
// memory with an incrementing address and closes the load on timeout or end.
module uart_loader #(
  parameter int unsigned ROM_DEPTH      = uart_loader_pkg::ROM_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_WIDTH  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upg_start_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 upg_active_o,
  output logic                 upg_wen_o,
  output logic [ROM_DEPTH:0]   upg_adr_o,
  output logic [31:0]          upg_dat_o,
  output logic                 upg_done_o,
  output logic                 upg_partial_o,
  output logic [ROM_DEPTH+1:0] upg_words_o
);
  import uart_loader_pkg::*;

  localparam int unsigned ADR_W   = ROM_DEPTH + 1;
  localparam int unsigned WORDS_W = ROM_DEPTH + 2;
  localparam logic [ADR_W-1:0]         ADR_MAX  = '1;
  localparam logic [TIMEOUT_WIDTH-1:0] IDLE_MAX = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  upg_state_e               state_q, state_d;
  logic [ADR_W-1:0]         adr_q, adr_d;
  logic [WORDS_W-1:0]       words_q, words_d;
  logic [TIMEOUT_WIDTH-1:0] idle_q, idle_d;
  logic                     partial_q, partial_d;
  logic                     active_q, active_d;
  logic                     done_q, done_d;

  logic                     asm_clear, asm_en, word_done;
  logic [BYTE_CNT_W-1:0]    byte_cnt;
  logic [ISA_WIDTH-1:0]     word;

  uart_word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (asm_clear),
    .en_i        (asm_en),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .byte_cnt_o  (byte_cnt),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    words_d   = words_q;
    idle_d    = idle_q;
    partial_d = partial_q;
    asm_clear = 1'b0;
    asm_en    = 1'b0;
    unique case (state_q)
      UPG_ST_IDLE: begin
        if (upg_start_i) begin
          state_d   = UPG_ST_RECV;
          adr_d     = '0;
          words_d   = '0;
          idle_d    = '0;
          partial_d = 1'b0;
          asm_clear = 1'b1;
        end
      end
      UPG_ST_RECV: begin
        asm_en = 1'b1;
        idle_d = rx_valid_i ? '0 : idle_q + TIMEOUT_WIDTH'(1);
        // The last address is written but never wrapped; it ends the load.
        if (word_done) begin
          words_d = words_q + WORDS_W'(1);
          if (adr_q == ADR_MAX) state_d = UPG_ST_DONE;
          else                  adr_d   = adr_q + ADR_W'(1);
        end else if (!rx_valid_i && idle_q == IDLE_MAX) begin
          state_d   = UPG_ST_DONE;
          partial_d = partial_q | (byte_cnt != '0);
        end
      end
      UPG_ST_DONE: state_d = UPG_ST_IDLE;
      default:     state_d = UPG_ST_IDLE;
    endcase
    active_d = (state_d == UPG_ST_RECV);
    done_d   = (state_d == UPG_ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UPG_ST_IDLE;
      adr_q     <= '0;
      words_q   <= '0;
      idle_q    <= '0;
      partial_q <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      words_q   <= words_d;
      idle_q    <= idle_d;
      partial_q <= partial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

  assign upg_active_o  = active_q;
  assign upg_wen_o     = word_done;
  assign upg_adr_o     = adr_q;
  assign upg_dat_o     = word;
  assign upg_done_o    = done_q;
  assign upg_partial_o = partial_q;
  assign upg_words_o   = words_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with ROM_DEPTH=2 and a 16-cycle timeout.
module tb_uart_loader;

  localparam int unsigned RD = 2;

  logic          clk = 1'b0;
  logic          rst, upg_start, rx_valid;
  logic [7:0]    rx_data;
  logic          upg_active, upg_wen, upg_done, upg_partial;
  logic [RD:0]   upg_adr;
  logic [31:0]   upg_dat;
  logic [RD+1:0] upg_words;

  int n_checks = 0;
  int n_fail   = 0;

  uart_loader #(.ROM_DEPTH(RD), .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .upg_start_i  (upg_start),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .upg_active_o (upg_active),
    .upg_wen_o    (upg_wen),
    .upg_adr_o    (upg_adr),
    .upg_dat_o    (upg_dat),
    .upg_done_o   (upg_done),
    .upg_partial_o(upg_partial),
    .upg_words_o  (upg_words)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Ticks until upg_done (cyc = ticks taken, -1 if never); counts strobes seen.
  task automatic wait_done(input int max, output int cyc, output int wens);
    cyc  = -1;
    wens = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (upg_wen) wens++;
      if (upg_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"},  32'(upg_active),  32'd0);
    check({tag, "_wen"},     32'(upg_wen),     32'd0);
    check({tag, "_adr"},     32'(upg_adr),     32'd0);
    check({tag, "_dat"},     upg_dat,          32'd0);
    check({tag, "_done"},    32'(upg_done),    32'd0);
    check({tag, "_partial"}, 32'(upg_partial), 32'd0);
    check({tag, "_words"},   32'(upg_words),   32'd0);
  endtask

  initial begin
    int cyc, wens, ns;
    logic [31:0] e;
    logic [7:0]  b1 [4];
    logic [7:0]  b5 [4];
    b1 = '{8'h78, 8'h56, 8'h34, 8'h12};
    b5 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    rst = 1'b1; upg_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Basic write
    upg_start = 1'b1; tick(); upg_start = 1'b0;
    check("t1_active", 32'(upg_active), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send_byte(b1[i]);
      if (i < 3) check("t1_no_early_wen", 32'(upg_wen), 32'd0);
    end
    check("t1_wen", 32'(upg_wen), 32'd1);
    check("t1_dat", upg_dat, 32'h12345678);
    check("t1_adr", 32'(upg_adr), 32'd0);
    tick();
    check("t1_wen_pulse", 32'(upg_wen), 32'd0);
    check("t1_adr_inc", 32'(upg_adr), 32'd1);
    check("t1_words", 32'(upg_words), 32'd1);

    // upg_start while in RECV must be ignored
    upg_start = 1'b1; tick(); upg_start = 1'b0;
    check("t6_start_recv_adr", 32'(upg_adr), 32'd1);
    check("t6_start_recv_words", 32'(upg_words), 32'd1);
    check("t6_start_recv_active", 32'(upg_active), 32'd1);
    wait_done(40, cyc, wens);
    check("t1_done_seen", 32'(cyc > 0), 32'd1);
    check("t1_done_words", 32'(upg_words), 32'd1);
    check("t1_done_partial", 32'(upg_partial), 32'd0);
    check("t1_done_active", 32'(upg_active), 32'd0);
    tick();
    check("t1_done_pulse", 32'(upg_done), 32'd0);

    // Gapless 32-byte stream fills all 8 addresses
    upg_start = 1'b1; tick(); upg_start = 1'b0;
    ns = 0;
    for (int k = 0; k < 32; k++) begin
      send_byte(8'(k));
      if (upg_wen) begin
        e = {8'(4*ns+3), 8'(4*ns+2), 8'(4*ns+1), 8'(4*ns)};
        check("t2_adr", 32'(upg_adr), 32'(ns));
        check("t2_dat", upg_dat, e);
        check("t2_spacing", 32'(k), 32'(4*ns+3));
        ns++;
      end
      if (k < 31) check("t2_no_done", 32'(upg_done), 32'd0);
    end
    check("t2_strobes", 32'(ns), 32'd8);
    tick();
    check("t2_done", 32'(upg_done), 32'd1);
    check("t2_adr_no_wrap", 32'(upg_adr), 32'd7);
    check("t2_words", 32'(upg_words), 32'd8);
    check("t2_wen_after", 32'(upg_wen), 32'd0);
    tick();
    check("t2_done_pulse", 32'(upg_done), 32'd0);

    // Timeout with a partial word
    upg_start = 1'b1; tick(); upg_start = 1'b0;
    check("t3_words_clr", 32'(upg_words), 32'd0);
    ns = 0;
    for (int k = 0; k < 6; k++) begin
      send_byte(8'hA0 + 8'(k));
      if (upg_wen) begin
        ns++;
        check("t3_adr", 32'(upg_adr), 32'd0);
        check("t3_dat", upg_dat, 32'hA3A2A1A0);
      end
    end
    check("t3_one_write", 32'(ns), 32'd1);
    wait_done(40, cyc, wens);
    check("t3_done_latency", 32'(cyc), 32'd16);
    check("t3_no_second_write", 32'(wens), 32'd0);
    check("t3_partial", 32'(upg_partial), 32'd1);
    check("t3_words", 32'(upg_words), 32'd1);

    // rx_valid in IDLE must be ignored
    tick();
    send_byte(8'hFF);
    check("t6_idle_active", 32'(upg_active), 32'd0);
    check("t6_idle_partial", 32'(upg_partial), 32'd1);
    check("t6_idle_dat", upg_dat, 32'hA3A2A5A4);
    check("t6_idle_adr", 32'(upg_adr), 32'd1);
    tick();
    check("t6_idle_wen", 32'(upg_wen), 32'd0);

    // Empty load
    upg_start = 1'b1; tick(); upg_start = 1'b0;
    check("t4_partial_clr", 32'(upg_partial), 32'd0);
    check("t4_adr_clr", 32'(upg_adr), 32'd0);
    wait_done(40, cyc, wens);
    check("t4_done_latency", 32'(cyc), 32'd16);
    check("t4_words", 32'(upg_words), 32'd0);
    check("t4_partial", 32'(upg_partial), 32'd0);
    check("t4_wens", 32'(wens), 32'd0);
    tick();

    // Reset mid-load, then a clean load
    upg_start = 1'b1; tick(); upg_start = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all_zero("t5_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_done", 32'(upg_done), 32'd0);
    end
    upg_start = 1'b1; tick(); upg_start = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(b5[i]);
    check("t5_wen", 32'(upg_wen), 32'd1);
    check("t5_dat", upg_dat, 32'hDEADBEEF);
    check("t5_adr", 32'(upg_adr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
Upstream feeder of the instruction-fetch stage's UART programming path. It takes the byte stream from the UART receiver, assembles little-endian 32-bit words, and issues single-cycle write strobes with an incrementing word address. The address MSB selects instruction memory (0) or data memory (1). It signals completion to the hazard unit, which then releases the pipeline and resets the PC.

Parameters:
ROM_DEPTH, 14, word-address bits per memory region; the full address is ROM_DEPTH+1 bits.
TIMEOUT_CYCLES, 1000000, idle cycles in RECV with no byte before the load is closed.
TIMEOUT_WIDTH, 20, width of the idle counter; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
upg_start  in  1  single-cycle request from the hazard unit to begin a load.
rx_valid  in  1  single-cycle strobe: one received byte on rx_data.
rx_data  in  8  received byte.
upg_active  out  1  high while in RECV; the hazard unit derives uart_disable from it.
upg_wen  out  1  single-cycle write strobe to instruction and data memory.
upg_adr  out  ROM_DEPTH+1  word address; MSB 0 selects instruction memory, 1 selects data memory.
upg_dat  out  32  assembled word.
upg_done  out  1  single-cycle pulse when the load ends.
upg_partial  out  1  sticky flag: a partial word (1-3 bytes) was discarded on timeout; cleared by upg_start or rst.
upg_words  out  ROM_DEPTH+2  number of words written in the current or last load.

Behaviour:
- Reset (rst=1 at a clock edge) overrides everything and is valid mid-load. All outputs go to 0: state IDLE, byte_cnt 0, idle counter 0, address 0, assembly register 0. The half-written load is abandoned and upg_done is not pulsed.
- States: IDLE, RECV, DONE.
- IDLE:
  - upg_start moves to RECV on the next cycle.
  - The same edge clears upg_adr, upg_words, byte_cnt, the idle counter and upg_partial.
  - rx_valid is ignored.
- RECV:
  - Each rx_valid writes rx_data into byte lane byte_cnt of the assembly register. Byte 0 is bits 7:0; byte 3 is bits 31:24.
  - byte_cnt is 2 bits and wraps 3 -> 0.
  - Word completion: when rx_valid arrives with byte_cnt=3, the next cycle shows upg_wen=1, upg_dat = the full word and upg_adr = the current address. This is a 1-cycle latency from the 4th byte.
  - On the cycle upg_wen is high, upg_adr and upg_words each increment by 1, so the new values are visible the cycle after the strobe.
  - A byte arriving in the upg_wen cycle goes into lane 0 of the next word; no bytes are lost, even back-to-back.
  - Back-to-back rx_valid every cycle is supported, giving one write per 4 cycles.
  - The idle counter clears on every rx_valid and increments on every other RECV cycle. It starts at 0 on entry, so an empty load also times out.
  - Timeout: when the counter equals TIMEOUT_CYCLES-1 with no rx_valid, go to DONE. If byte_cnt != 0, the partial word is dropped and upg_partial is set. No write is issued.
  - Address end: when the write at address 2^(ROM_DEPTH+1)-1 is strobed, go to DONE. The address does not wrap to 0.
  - upg_start while in RECV is ignored.
- DONE:
  - upg_done=1 for exactly one cycle, then IDLE.
  - rx_valid and upg_start are ignored.
- Simultaneous timeout-equal and rx_valid: rx_valid wins; the byte is captured and the counter is cleared.
- upg_wen is a registered pulse and is never high for two consecutive cycles.

Decomposition:
- Shared definitions file gets:
  - UPG_ST_IDLE, UPG_ST_RECV, UPG_ST_DONE (2-bit state encodings);
  - UART_BYTE_WIDTH = 8;
  - the existing ISA_WIDTH and ROM_DEPTH.
- One natural sub-module, uart_word_assembler: byte_cnt, the lane-write assembly register and the word-complete pulse.
- The FSM, address counter, idle counter and flags stay in uart_loader.

Test Plan:
1. Basic write. Bench uses ROM_DEPTH=2, TIMEOUT_CYCLES=16. Pulse upg_start, then send bytes 0x78,0x56,0x34,0x12 on 4 consecutive cycles.
   -> One upg_wen, the cycle after the 4th byte, with upg_dat=0x12345678 and upg_adr=0; upg_words becomes 1.
2. Back-to-back gapless stream of 32 bytes.
   -> 8 strobes with upg_adr 0..7, exactly 4 cycles apart. upg_done fires 1 cycle after the strobe at address 7. upg_adr never wraps.
3. Timeout with a partial word. Send 6 bytes, then stay silent.
   -> One write at address 0. upg_done fires 16 cycles after the last byte. upg_partial=1; no second write; upg_words=1.
4. Empty load: upg_start, then no bytes.
   -> upg_done 16 cycles after entering RECV; upg_words=0; upg_partial=0.
5. Reset mid-load. Assert rst for one cycle after 2 bytes, then restart with 0xEF,0xBE,0xAD,0xDE.
   -> No upg_done from the aborted load; all outputs are 0 after reset. The new load writes 0xDEADBEEF at address 0.
6. Ignored inputs: rx_valid while in IDLE, and upg_start while in RECV.
   -> No state change, no capture, the address is not reset, and upg_partial is not cleared.
